// File: rtl/insn_encoder_if.sv
// Host-side load request, encode-tuple stream and instruction-memory write port
// of the kanade32 instruction encoder, bundled as one interface.
interface insn_encoder_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  count;

   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_mnem;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;

   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   logic              busy;
   logic              done;
   logic              illegal;

   modport slave (
      input  start, base_addr, count,
      input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
      input  mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, illegal
   );

   modport master (
      output start, base_addr, count,
      output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
      output mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, illegal
   );
endinterface

// File: rtl/insn_encoder.sv
// Packs mnemonic/field tuples into kanade32 machine words and streams them to
// instruction memory at consecutive word addresses, one word per cycle.
module insn_encoder #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input logic           clk,
   input logic           rst,
   insn_encoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  remaining_q;
   logic              illegal_q;
   logic              done_q, done_d;

   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [31:0]       word_p1;

   logic              accept, out_hs, load_start;
   logic [31:0]       enc_word;
   logic              enc_ill;

   function automatic logic [5:0] r_funct(input logic [4:0] mnem);
      case (mnem)
         5'd0:    r_funct = 6'b100000;
         5'd1:    r_funct = 6'b100001;
         5'd2:    r_funct = 6'b100010;
         5'd3:    r_funct = 6'b100011;
         5'd4:    r_funct = 6'b100100;
         5'd5:    r_funct = 6'b100101;
         5'd6:    r_funct = 6'b100110;
         5'd7:    r_funct = 6'b100111;
         5'd8:    r_funct = 6'b101010;
         5'd9:    r_funct = 6'b101011;
         default: r_funct = 6'b000000;
      endcase
   endfunction

   function automatic logic [5:0] i_op(input logic [4:0] mnem);
      case (mnem)
         5'd13:   i_op = 6'b000100;
         5'd14:   i_op = 6'b000101;
         5'd15:   i_op = 6'b000001;
         5'd16:   i_op = 6'b000110;
         5'd17:   i_op = 6'b001000;
         5'd18:   i_op = 6'b001001;
         5'd19:   i_op = 6'b001100;
         5'd20:   i_op = 6'b001101;
         5'd21:   i_op = 6'b001010;
         5'd22:   i_op = 6'b001011;
         5'd23:   i_op = 6'b001110;
         5'd24:   i_op = 6'b100011;
         5'd25:   i_op = 6'b101011;
         default: i_op = 6'b000000;
      endcase
   endfunction

   // Returns {illegal, word}; unknown mnemonics encode as an all-zero word.
   function automatic logic [32:0] encode(
      input logic [4:0]  mnem,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      logic [31:0] w;
      logic        ill;
      w   = 32'h0000_0000;
      ill = 1'b0;
      if (mnem <= 5'd9)
         w = {6'b000000, rs, rt, rd, 5'b00000, r_funct(mnem)};
      else if (mnem == 5'd10)
         w = {6'b000000, rs, 15'b0, 6'b001000};
      else if (mnem == 5'd11)
         w = {6'b000010, target};
      else if (mnem == 5'd12)
         w = {6'b000011, target};
      else if (mnem <= 5'd25)
         w = {i_op(mnem), rs, rt, imm};
      else
         ill = 1'b1;
      encode = {ill, w};
   endfunction

   always_comb begin
      {enc_ill, enc_word} = encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd,
                                   bus.in_imm, bus.in_target);
   end

   // Backpressure reaches in_ready combinationally so a stalled word is never overwritten.
   assign bus.in_ready = (state_q == RUN) && (remaining_q != '0) && (!vld_p1 || bus.mem_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign out_hs       = vld_p1 && bus.mem_ready;
   assign load_start   = (state_q == IDLE) && bus.start;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.count != '0) state_d = RUN;
               else                 done_d  = 1'b1;
            end
         end
         RUN: begin
            if (accept && remaining_q == CNT_W'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (out_hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Load bookkeeping: write pointer, words left, sticky illegal flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         remaining_q <= '0;
         illegal_q   <= 1'b0;
      end else if (load_start) begin
         addr_q      <= bus.base_addr & ~ADDR_W'(3);
         remaining_q <= bus.count;
         illegal_q   <= 1'b0;
      end else if (accept) begin
         addr_q      <= addr_q + ADDR_W'(4);
         remaining_q <= remaining_q - CNT_W'(1);
         if (enc_ill) illegal_q <= 1'b1;
      end
   end

   // ---- stage p1: output register toward instruction memory ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         word_p1 <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         addr_p1 <= addr_q;
         word_p1 <= enc_word;
      end else if (out_hs) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.mem_we    = vld_p1;
   assign bus.mem_addr  = addr_p1;
   assign bus.mem_wdata = word_p1;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: hand-encoded words, addresses, handshakes,
// backpressure, illegal mnemonics, address wrap and reset behaviour.
module tb_insn_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   insn_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();
   insn_encoder_if #(.ADDR_W(8),  .CNT_W(16)) bus8 ();

   insn_encoder #(.ADDR_W(32), .CNT_W(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   insn_encoder #(.ADDR_W(8), .CNT_W(16)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [31:0] base, input logic [15:0] cnt);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.count     = cnt;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic tuple(input logic [4:0] mnem, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      bus.in_valid  = 1'b1;
      bus.in_mnem   = mnem;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_imm    = imm;
      bus.in_target = tgt;
   endtask

   initial begin
      bus.start = 0; bus.base_addr = 0; bus.count = 0; bus.in_valid = 0;
      bus.in_mnem = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
      bus.in_imm = 0; bus.in_target = 0; bus.mem_ready = 0;
      bus8.start = 0; bus8.base_addr = 0; bus8.count = 0; bus8.in_valid = 0;
      bus8.in_mnem = 0; bus8.in_rs = 0; bus8.in_rt = 0; bus8.in_rd = 0;
      bus8.in_imm = 0; bus8.in_target = 0; bus8.mem_ready = 0;

      // Reset state
      repeat (3) tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_illegal", bus.illegal, 0);
      rst = 1'b0;
      tick();

      // Single add at 0x100
      bus.mem_ready = 1'b1;
      start_load(32'h100, 16'd1);
      chk("t1_busy", bus.busy, 1);
      chk("t1_in_ready", bus.in_ready, 1);
      tuple(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      tick();
      bus.in_valid = 1'b0;
      chk("t1_we", bus.mem_we, 1);
      chk("t1_wdata", bus.mem_wdata, 32'h0022_1820);
      chk("t1_addr", bus.mem_addr, 32'h100);
      chk("t1_drain_ready", bus.in_ready, 0);
      tick();
      chk("t1_done", bus.done, 1);
      chk("t1_busy_off", bus.busy, 0);
      chk("t1_we_off", bus.mem_we, 0);
      tick();
      chk("t1_done_pulse", bus.done, 0);

      // Mixed four-word load, back to back
      start_load(32'h0, 16'd4);
      tuple(5'd17, 5'd0, 5'd4, 5'd0, 16'h0005, 26'h0);
      tick();
      chk("t2_w0", bus.mem_wdata, 32'h2004_0005);
      chk("t2_a0", bus.mem_addr, 32'h0);
      tuple(5'd24, 5'd29, 5'd8, 5'd0, 16'h0010, 26'h0);
      tick();
      chk("t2_w1", bus.mem_wdata, 32'h8FA8_0010);
      chk("t2_a1", bus.mem_addr, 32'h4);
      tuple(5'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0040);
      tick();
      chk("t2_w2", bus.mem_wdata, 32'h0C00_0040);
      chk("t2_a2", bus.mem_addr, 32'h8);
      tuple(5'd10, 5'd31, 5'd5, 5'd7, 16'h0, 26'h0);
      tick();
      bus.in_valid = 1'b0;
      chk("t2_w3", bus.mem_wdata, 32'h03E0_0008);
      chk("t2_a3", bus.mem_addr, 32'hC);
      chk("t2_we3", bus.mem_we, 1);
      tick();
      chk("t2_done", bus.done, 1);

      // Backpressure: mem_ready low for 3 cycles
      start_load(32'h200, 16'd2);
      bus.mem_ready = 1'b0;
      tuple(5'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
      tick();
      tuple(5'd5, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
      for (int i = 0; i < 3; i++) begin
         chk("t3_in_ready_low", bus.in_ready, 0);
         chk("t3_we_hold", bus.mem_we, 1);
         chk("t3_addr_hold", bus.mem_addr, 32'h200);
         chk("t3_wdata_hold", bus.mem_wdata, 32'h0085_3022);
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("t3_in_ready_back", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("t3_w1", bus.mem_wdata, 32'h00E8_4825);
      chk("t3_a1", bus.mem_addr, 32'h204);
      chk("t3_we1", bus.mem_we, 1);
      tick();
      chk("t3_done", bus.done, 1);

      // Illegal mnemonic inside a two-word load
      start_load(32'h300, 16'd2);
      tuple(5'd30, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h3FF_FFFF);
      tick();
      chk("t4_w0", bus.mem_wdata, 32'h0);
      chk("t4_a0", bus.mem_addr, 32'h300);
      chk("t4_we0", bus.mem_we, 1);
      chk("t4_ill", bus.illegal, 1);
      tuple(5'd20, 5'd1, 5'd2, 5'd0, 16'hBEEF, 26'h0);
      tick();
      bus.in_valid = 1'b0;
      chk("t4_w1", bus.mem_wdata, 32'h3422_BEEF);
      chk("t4_a1", bus.mem_addr, 32'h304);
      chk("t4_ill_sticky", bus.illegal, 1);
      tick();
      chk("t4_done", bus.done, 1);
      chk("t4_ill_after", bus.illegal, 1);
      tick();

      // start with count 0 (also clears illegal)
      start_load(32'h0, 16'd0);
      chk("t5_done", bus.done, 1);
      chk("t5_busy", bus.busy, 0);
      chk("t5_ill_clr", bus.illegal, 0);
      tick();
      chk("t5_done_pulse", bus.done, 0);
      chk("t5_busy2", bus.busy, 0);

      // start while busy is ignored
      start_load(32'h400, 16'd1);
      bus.start = 1'b1; bus.base_addr = 32'h800; bus.count = 16'd5;
      tuple(5'd23, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0);
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      chk("t6_addr", bus.mem_addr, 32'h400);
      chk("t6_wdata", bus.mem_wdata, 32'h3864_00FF);
      tick();
      chk("t6_done", bus.done, 1);
      tick();
      chk("t6_idle", bus.busy, 0);

      // Asynchronous reset mid-load
      start_load(32'h500, 16'd3);
      bus.mem_ready = 1'b0;
      tuple(5'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      tick();
      bus.in_valid = 1'b0;
      chk("t7_wdata", bus.mem_wdata, 32'h0022_182A);
      #2 rst = 1'b1;
      #1;
      chk("t7_we", bus.mem_we, 0);
      chk("t7_addr", bus.mem_addr, 0);
      chk("t7_wdata_clr", bus.mem_wdata, 0);
      chk("t7_busy", bus.busy, 0);
      chk("t7_in_ready", bus.in_ready, 0);
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      chk("t7_no_done", bus.done, 0);
      chk("t7_still_idle", bus.busy, 0);

      // Address wrap on the 8-bit instance
      bus8.mem_ready = 1'b1;
      bus8.start = 1'b1; bus8.base_addr = 8'hFF; bus8.count = 16'd2;
      tick();
      bus8.start = 1'b0;
      bus8.in_valid = 1'b1; bus8.in_mnem = 5'd25; bus8.in_rs = 5'd2;
      bus8.in_rt = 5'd3; bus8.in_imm = 16'hFFFC;
      tick();
      chk("t8_a0", bus8.mem_addr, 8'hFC);
      chk("t8_w0", bus8.mem_wdata, 32'hAC43_FFFC);
      bus8.in_mnem = 5'd13; bus8.in_rs = 5'd1; bus8.in_rt = 5'd0; bus8.in_imm = 16'h0001;
      tick();
      bus8.in_valid = 1'b0;
      chk("t8_a1", bus8.mem_addr, 8'h00);
      chk("t8_w1", bus8.mem_wdata, 32'h1020_0001);
      tick();
      chk("t8_done", bus8.done, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
